// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates Tout signed partial-sum lanes over a configurable number of
// input-channel tiles and emits the completed sums on a registered valid/ready output.
// Optional build macro PSUM_ACC_SAT_EN: saturating accumulation plus an o_sat flag port;
// without it, lanes wrap in two's complement and o_sat does not exist.
module psum_accumulator #(
  parameter int unsigned Tout   = 8,
  parameter int unsigned IN_DW  = 20,
  parameter int unsigned ACC_DW = 32,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cfg_tiles,
  input  logic                   i_flush,
  input  logic                   i_vld,
  output logic                   i_rdy,
  input  logic [IN_DW*Tout-1:0]  i_dat,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [ACC_DW*Tout-1:0] o_dat
`ifdef PSUM_ACC_SAT_EN
  ,
  output logic                   o_sat
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [ACC_DW-1:0] AccMax = {1'b0, {(ACC_DW-1){1'b1}}};
  localparam logic [ACC_DW-1:0] AccMin = {1'b1, {(ACC_DW-1){1'b0}}};
`endif

  logic [0:0]             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       n_q;
  logic [CNT_W-1:0]       n_cur;
  logic [ACC_DW*Tout-1:0] acc_q;
  logic [ACC_DW*Tout-1:0] sum_flat;
  logic                   first;
  logic                   accept;
  logic                   last;
`ifdef PSUM_ACC_SAT_EN
  logic [Tout-1:0]        lane_sat;
  logic                   sat_q;
  logic                   grp_sat;
`endif

  // Input handshake: free slot when no result is pending or it leaves this cycle.
  assign i_rdy  = ~rst & (~o_vld | o_rdy);
  assign accept = i_vld & i_rdy;
  assign first  = (state_q == IDLE);

  // Group length: latch cfg_tiles on the first beat, otherwise use the latched value.
  always_comb begin
    n_cur = n_q;
    if (first) begin
      n_cur = (cfg_tiles == '0) ? CNT_W'(1) : cfg_tiles;
    end
    last = (cnt_q == n_cur - CNT_W'(1));
  end

  // Per-lane sign extension and accumulate; the first beat of a group loads directly.
  always_comb begin
    logic signed [ACC_DW-1:0] ext_l;
    logic signed [ACC_DW-1:0] acc_l;
`ifdef PSUM_ACC_SAT_EN
    logic        [ACC_DW:0]   wide;
    wide     = '0;
    lane_sat = '0;
`endif
    ext_l    = '0;
    acc_l    = '0;
    sum_flat = '0;
    for (int k = 0; k < int'(Tout); k++) begin
      ext_l = ACC_DW'(signed'(i_dat[k*IN_DW +: IN_DW]));
      acc_l = signed'(acc_q[k*ACC_DW +: ACC_DW]);
`ifdef PSUM_ACC_SAT_EN
      // One extra bit exposes overflow: top two bits disagree when out of range.
      wide = {acc_l[ACC_DW-1], acc_l} + {ext_l[ACC_DW-1], ext_l};
      if (first) begin
        sum_flat[k*ACC_DW +: ACC_DW] = ext_l;
      end else if (wide[ACC_DW] != wide[ACC_DW-1]) begin
        sum_flat[k*ACC_DW +: ACC_DW] = wide[ACC_DW] ? AccMin : AccMax;
        lane_sat[k] = 1'b1;
      end else begin
        sum_flat[k*ACC_DW +: ACC_DW] = wide[ACC_DW-1:0];
      end
`else
      sum_flat[k*ACC_DW +: ACC_DW] = first ? ext_l : acc_l + ext_l;
`endif
    end
  end

`ifdef PSUM_ACC_SAT_EN
  // Sticky group status restarts with each new group.
  assign grp_sat = (first ? 1'b0 : sat_q) | (|lane_sat);
`endif

  // Group FSM, accumulators and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      o_vld   <= 1'b0;
      o_dat   <= '0;
`ifdef PSUM_ACC_SAT_EN
      sat_q   <= 1'b0;
      o_sat   <= 1'b0;
`endif
    end else begin
      if (o_vld && o_rdy) begin
        o_vld <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
        o_sat <= 1'b0;
`endif
      end
      if (i_flush) begin
        // Any beat accepted alongside a flush is dropped; a pending result survives.
        state_q <= IDLE;
        cnt_q   <= '0;
`ifdef PSUM_ACC_SAT_EN
        sat_q   <= 1'b0;
`endif
      end else if (accept) begin
        if (last) begin
          o_vld   <= 1'b1;
          o_dat   <= sum_flat;
          state_q <= IDLE;
          cnt_q   <= '0;
`ifdef PSUM_ACC_SAT_EN
          o_sat   <= grp_sat;
          sat_q   <= 1'b0;
`endif
        end else begin
          acc_q   <= sum_flat;
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= ACCUM;
          if (first) begin
            n_q <= n_cur;
          end
`ifdef PSUM_ACC_SAT_EN
          sat_q   <= grp_sat;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator with a behavioural group model.
// Uses ACC_DW=24 so the saturation / wrap case is reachable; honours PSUM_ACC_SAT_EN.
module tb_psum_accumulator;

  localparam int TOUT   = 8;
  localparam int IN_DW  = 20;
  localparam int ACC_DW = 24;
  localparam int CNT_W  = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [CNT_W-1:0]       cfg_tiles = '0;
  logic                   i_flush = 1'b0;
  logic                   i_vld = 1'b0;
  logic                   i_rdy;
  logic [IN_DW*TOUT-1:0]  i_dat = '0;
  logic                   o_vld;
  logic                   o_rdy = 1'b0;
  logic [ACC_DW*TOUT-1:0] o_dat;
`ifdef PSUM_ACC_SAT_EN
  logic                   o_sat;
`endif

  psum_accumulator #(
    .Tout   (TOUT),
    .IN_DW  (IN_DW),
    .ACC_DW (ACC_DW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_tiles (cfg_tiles),
    .i_flush   (i_flush),
    .i_vld     (i_vld),
    .i_rdy     (i_rdy),
    .i_dat     (i_dat),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .o_dat     (o_dat)
`ifdef PSUM_ACC_SAT_EN
    ,
    .o_sat     (o_sat)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: true lane values, bounded to ACC_DW by wrap or saturation.
  longint beat  [TOUT];
  longint m_acc [TOUT];
  longint m_dat [TOUT];
  bit     m_pend = 1'b0;
  bit     m_busy = 1'b0;
  bit     m_gsat = 1'b0;
  bit     m_osat = 1'b0;
  int     m_cnt  = 0;
  int     m_n    = 1;
  bit     m_rdy;
  bit     obs_rdy;

  function automatic longint bound(input longint x);
    logic signed [ACC_DW-1:0] t;
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (ACC_DW - 1)) - 1;
    lo = -(64'sd1 <<< (ACC_DW - 1));
`ifdef PSUM_ACC_SAT_EN
    if (x > hi) begin
      m_gsat = 1'b1;
      return hi;
    end
    if (x < lo) begin
      m_gsat = 1'b1;
      return lo;
    end
    return x;
`else
    t = x[ACC_DW-1:0];
    return longint'(t);
`endif
  endfunction

  function automatic logic [ACC_DW*TOUT-1:0] exp_dat();
    logic [ACC_DW*TOUT-1:0] p;
    p = '0;
    for (int k = 0; k < TOUT; k++) p[k*ACC_DW +: ACC_DW] = m_dat[k][ACC_DW-1:0];
    return p;
  endfunction

  function automatic longint rnd_lane();
    logic signed [IN_DW-1:0] v;
    v = IN_DW'($urandom);
    return longint'(v);
  endfunction

  // Drive one clock of stimulus and advance the model by the spec's rules.
  task automatic cycle(input bit vld, input bit flush, input int tiles, input bit ordy);
    i_vld     = vld;
    i_flush   = flush;
    cfg_tiles = CNT_W'(tiles);
    o_rdy     = ordy;
    for (int k = 0; k < TOUT; k++) i_dat[k*IN_DW +: IN_DW] = beat[k][IN_DW-1:0];
    #1;
    obs_rdy = i_rdy;
    m_rdy   = !rst && (!m_pend || ordy);
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_busy = 0; m_cnt = 0; m_gsat = 0; m_osat = 0;
      for (int k = 0; k < TOUT; k++) m_dat[k] = 0;
    end else begin
      if (m_pend && ordy) begin
        m_pend = 0;
        m_osat = 0;
      end
      if (flush) begin
        m_busy = 0;
        m_cnt  = 0;
      end else if (vld && m_rdy) begin
        if (!m_busy) begin
          m_n    = (tiles % (1 << CNT_W) == 0) ? 1 : tiles % (1 << CNT_W);
          m_cnt  = 0;
          m_gsat = 0;
          for (int k = 0; k < TOUT; k++) m_acc[k] = beat[k];
        end else begin
          for (int k = 0; k < TOUT; k++) m_acc[k] = bound(m_acc[k] + beat[k]);
        end
        if (m_cnt == m_n - 1) begin
          m_pend = 1;
          m_osat = m_gsat;
          m_dat  = m_acc;
          m_busy = 0;
          m_cnt  = 0;
        end else begin
          m_busy = 1;
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [ACC_DW*TOUT-1:0] zero;
    zero = '0;
    rst = 1'b1;
    for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
    for (int j = 0; j < 2; j++) begin
      cycle(1, 0, 4, 1);
      total++;
      if (obs_rdy !== 1'b0) begin
        bad++; $display("FAIL reset_rdy got=%b want=0", obs_rdy);
      end
      total++;
      if (o_vld !== 1'b0 || o_dat !== zero) begin
        bad++; $display("FAIL reset_out o_vld=%b o_dat=%h want 0/0", o_vld, o_dat);
      end
`ifdef PSUM_ACC_SAT_EN
      total++;
      if (o_sat !== 1'b0) begin
        bad++; $display("FAIL reset_sat got=%b want=0", o_sat);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [ACC_DW-1:0] want;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < TOUT; k++) beat[k] = (j + 1) * (k + 1);
      cycle(j < 4, 0, 4, 1);
      total++;
      if (o_vld !== m_pend || o_dat !== exp_dat() || o_vld !== (j == 3)) begin
        bad++;
        $display("FAIL basic j=%0d o_vld=%b o_dat=%h want_vld=%b want_dat=%h", j, o_vld, o_dat,
                 m_pend, exp_dat());
      end
    end
    // o_dat holds the last result after the pulse.
    for (int k = 0; k < TOUT; k++) begin
      want = ACC_DW'(10 * (k + 1));
      total++;
      if (o_dat[k*ACC_DW +: ACC_DW] !== want) begin
        bad++; $display("FAIL basic_lane k=%0d got=%0d want=%0d", k, o_dat[k*ACC_DW +: ACC_DW],
                        want);
      end
    end
  endtask

  task automatic test_neg_n1();
    logic [ACC_DW-1:0] want;
    want = {{(ACC_DW-3){1'b1}}, 3'b011};
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
      beat[0] = -5;
      cycle(1, 0, t, 1);
      total++;
      if (o_vld !== 1'b1 || o_dat !== exp_dat() || o_dat[ACC_DW-1:0] !== want) begin
        bad++;
        $display("FAIL neg_n1 tiles=%0d o_vld=%b o_dat=%h want_dat=%h", t, o_vld, o_dat,
                 exp_dat());
      end
    end
    cycle(0, 0, 0, 1);
    total++;
    if (o_vld !== 1'b0) begin
      bad++; $display("FAIL neg_n1_clear o_vld=%b want=0", o_vld);
    end
  endtask

  task automatic test_backpressure();
    bit ordy_pat [12] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
    for (int j = 0; j < 12; j++) begin
      cycle(1, 0, 2, ordy_pat[j]);
      total++;
      if (obs_rdy !== m_rdy) begin
        bad++; $display("FAIL bp_rdy j=%0d got=%b want=%b", j, obs_rdy, m_rdy);
      end
      total++;
      if (o_vld !== m_pend || o_dat !== exp_dat()) begin
        bad++;
        $display("FAIL bp_out j=%0d o_vld=%b o_dat=%h want_vld=%b want_dat=%h", j, o_vld, o_dat,
                 m_pend, exp_dat());
      end
      // Valid/ready: a stalled beat is held, a taken one is replaced.
      if (m_rdy) for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
      cycle(1, 0, 2, 1);
      total++;
      if (obs_rdy !== 1'b1) begin
        bad++; $display("FAIL b2b_rdy j=%0d got=%b want=1", j, obs_rdy);
      end
      total++;
      if (o_vld !== (j % 2 == 1) || o_dat !== exp_dat()) begin
        bad++;
        $display("FAIL b2b_out j=%0d o_vld=%b o_dat=%h want_vld=%b want_dat=%h", j, o_vld, o_dat,
                 (j % 2 == 1), exp_dat());
      end
    end
  endtask

  task automatic test_flush_reset();
    logic [ACC_DW-1:0] three;
    three = ACC_DW'(3);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 0; k < TOUT; k++) beat[k] = 7;
        cycle(1, 0, 3, 1);
      end
      for (int k = 0; k < TOUT; k++) beat[k] = 100;
      if (r == 0) begin
        cycle(1, 1, 3, 1);
      end else begin
        rst = 1'b1;
        cycle(1, 0, 3, 1);
        rst = 1'b0;
        total++;
        if (o_vld !== 1'b0) begin
          bad++; $display("FAIL rst_mid_vld got=%b want=0", o_vld);
        end
      end
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < TOUT; k++) beat[k] = 1;
        cycle(1, 0, 3, 1);
        total++;
        if (o_vld !== m_pend || o_dat !== exp_dat() || o_vld !== (j == 2)) begin
          bad++;
          $display("FAIL flush r=%0d j=%0d o_vld=%b o_dat=%h want_dat=%h", r, j, o_vld, o_dat,
                   exp_dat());
        end
      end
      for (int k = 0; k < TOUT; k++) begin
        total++;
        if (o_dat[k*ACC_DW +: ACC_DW] !== three) begin
          bad++; $display("FAIL flush_lane r=%0d k=%0d got=%0d want=3", r, k,
                          o_dat[k*ACC_DW +: ACC_DW]);
        end
      end
    end
    // Reset while a result is pending discards it.
    for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
    cycle(1, 0, 1, 0);
    rst = 1'b1;
    cycle(0, 0, 1, 0);
    rst = 1'b0;
    total++;
    if (o_vld !== 1'b0) begin
      bad++; $display("FAIL rst_pending got=%b want=0", o_vld);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < TOUT; k++) beat[k] = rnd_lane();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4),
            $urandom_range(0, 9) < 7);
      total++;
      if (obs_rdy !== m_rdy || o_vld !== m_pend || o_dat !== exp_dat()) begin
        bad++;
        $display("FAIL random j=%0d rdy=%b/%b o_vld=%b/%b o_dat=%h want=%h", j, obs_rdy, m_rdy,
                 o_vld, m_pend, o_dat, exp_dat());
      end
`ifdef PSUM_ACC_SAT_EN
      total++;
      if (o_sat !== m_osat) begin
        bad++; $display("FAIL random_sat j=%0d got=%b want=%b", j, o_sat, m_osat);
      end
`endif
    end
    cycle(0, 1, 1, 1);
  endtask

  task automatic test_sat();
    logic [ACC_DW-1:0] want;
`ifdef PSUM_ACC_SAT_EN
    want = ACC_DW'(8388607);
`else
    want = ACC_DW'(4194264);
`endif
    for (int k = 0; k < TOUT; k++) beat[k] = 524287;
    for (int j = 0; j < 40; j++) cycle(1, 0, 40, 1);
    total++;
    if (o_vld !== 1'b1 || o_dat !== exp_dat() || o_dat[ACC_DW-1:0] !== want) begin
      bad++;
      $display("FAIL sat_val o_vld=%b lane0=%0d want=%0d o_dat=%h model=%h", o_vld,
               o_dat[ACC_DW-1:0], want, o_dat, exp_dat());
    end
`ifdef PSUM_ACC_SAT_EN
    total++;
    if (o_sat !== 1'b1) begin
      bad++; $display("FAIL sat_flag got=%b want=1", o_sat);
    end
`endif
    cycle(0, 0, 1, 1);
  endtask

  initial begin
    for (int k = 0; k < TOUT; k++) begin
      beat[k] = 0; m_acc[k] = 0; m_dat[k] = 0;
    end
    test_reset();
    test_basic();
    test_neg_n1();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    test_random();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
